// File: rtl/hazard_stall_ctrl_if.sv
// Purpose: groups the ID/EX/MEM hazard-relevant pipeline fields and the
//          pipeline gating controls that pass between the datapath and the
//          hazard/stall controller.
// Signals:
//   id_rs, id_rt, id_uses_rs, id_uses_rt    register operands of the instruction in ID
//   id_is_branch, id_is_jump, id_branch_taken  control-transfer info from ID
//   ex_regwrite, ex_memread, ex_waddr        ID/EX destination info
//   mem_regwrite, mem_memread, mem_waddr     EX/MEM destination info
//   pc_write, if_id_write                    register enables (1 = may update)
//   if_id_flush, id_ex_flush                 NOP / bubble insertion requests
// Modports: master = pipeline side, slave = hazard/stall controller.
interface hazard_stall_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_branch;
    logic       id_is_jump;
    logic       id_branch_taken;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_waddr;
    logic       mem_regwrite;
    logic       mem_memread;
    logic [4:0] mem_waddr;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_is_branch, id_is_jump, id_branch_taken,
        output ex_regwrite, ex_memread, ex_waddr,
        output mem_regwrite, mem_memread, mem_waddr,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_is_branch, id_is_jump, id_branch_taken,
        input  ex_regwrite, ex_memread, ex_waddr,
        input  mem_regwrite, mem_memread, mem_waddr,
        output pc_write, if_id_write, if_id_flush, id_ex_flush
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Purpose: hazard/stall controller for the 5-stage pipeline. Detects load-use
//          and ID-resolved branch/jr dependencies that forwarding cannot cover,
//          runs a 1- or 2-cycle stall countdown, flushes IF/ID on taken control
//          transfers, and keeps saturating stall/flush event counters.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   hz         pipeline hazard bus (slave side): ID/EX/MEM fields in,
//              pc_write / if_id_write / if_id_flush / id_ex_flush out
//              (combinational from state and inputs)
//   stall_cnt  stalling cycles since reset, saturating
//   flush_cnt  IF/ID flush cycles since reset, saturating
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_ctrl_if.slave hz,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned LEN_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL2 = 2'd1,
        ST_STALL1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               m_ex_c, m_mem_c;
    logic [LEN_W-1:0]   len_c;
    logic               stalling_c;
    logic               active_stall_c;
    logic               flush_c;

    // Producer match: a live, non-$0 destination that the ID instruction reads
    always_comb begin
        m_ex_c  = hz.ex_regwrite & (hz.ex_waddr != REG_W'(0)) &
                  ((hz.id_uses_rs & (hz.ex_waddr == hz.id_rs)) |
                   (hz.id_uses_rt & (hz.ex_waddr == hz.id_rt)));
        m_mem_c = hz.mem_regwrite & (hz.mem_waddr != REG_W'(0)) &
                  ((hz.id_uses_rs & (hz.mem_waddr == hz.id_rs)) |
                   (hz.id_uses_rt & (hz.mem_waddr == hz.id_rt)));
    end

    // Required stall length; branches in ID need operands one stage earlier
    always_comb begin
        len_c = LEN_W'(0);
        if (hz.id_is_branch) begin
            if (hz.ex_memread & m_ex_c) begin
                len_c = LEN_W'(2);
            end else if ((~hz.ex_memread & m_ex_c) | (hz.mem_memread & m_mem_c)) begin
                len_c = LEN_W'(1);
            end
        end else if (hz.ex_memread & m_ex_c) begin
            len_c = LEN_W'(1);
        end
    end

    // Countdown FSM next-state and stall qualifier
    always_comb begin
        state_d    = state_q;
        stalling_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (len_c == LEN_W'(2)) begin
                    state_d    = ST_STALL2;
                    stalling_c = 1'b1;
                end else if (len_c == LEN_W'(1)) begin
                    state_d    = ST_STALL1;
                    stalling_c = 1'b1;
                end
            end
            ST_STALL2: begin
                state_d    = ST_STALL1;
                stalling_c = 1'b1;
            end
            ST_STALL1: begin
                state_d    = ST_IDLE;
                stalling_c = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline gating; reset forces free-running flow, stall beats flush
    always_comb begin
        active_stall_c = rst_n & stalling_c;
        flush_c        = rst_n & ~stalling_c &
                         (hz.id_is_jump | (hz.id_is_branch & hz.id_branch_taken));
    end

    assign hz.pc_write    = ~active_stall_c;
    assign hz.if_id_write = ~active_stall_c;
    assign hz.id_ex_flush = active_stall_c;
    assign hz.if_id_flush = flush_c;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active_stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a cycle-level model of the stall/flush rules
// checked every cycle, plus hand-computed expectations at key points.
// A second instance with 4-bit counters exercises saturation.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if bus ();
    hazard_stall_ctrl_if bus4 ();

    logic [31:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    hazard_stall_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    hazard_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (bus4),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    // Narrow-counter instance sees the same pipeline traffic
    assign bus4.id_rs           = bus.id_rs;
    assign bus4.id_rt           = bus.id_rt;
    assign bus4.id_uses_rs      = bus.id_uses_rs;
    assign bus4.id_uses_rt      = bus.id_uses_rt;
    assign bus4.id_is_branch    = bus.id_is_branch;
    assign bus4.id_is_jump      = bus.id_is_jump;
    assign bus4.id_branch_taken = bus.id_branch_taken;
    assign bus4.ex_regwrite     = bus.ex_regwrite;
    assign bus4.ex_memread      = bus.ex_memread;
    assign bus4.ex_waddr        = bus.ex_waddr;
    assign bus4.mem_regwrite    = bus.mem_regwrite;
    assign bus4.mem_memread     = bus.mem_memread;
    assign bus4.mem_waddr       = bus.mem_waddr;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam longint MAX32 = 64'd4294967295;
    localparam longint MAX4  = 64'd15;

    int     m_rem = 0;          // stall cycles still owed after the detecting cycle
    longint m_sc  = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

    function automatic bool_dep(input logic [4:0] w, input logic we);
        return we && (w != 0) &&
               ((bus.id_uses_rs && w == bus.id_rs) || (bus.id_uses_rt && w == bus.id_rt));
    endfunction

    function automatic int calc_len();
        bit dep_ex, dep_mem;
        int l;
        dep_ex  = bool_dep(bus.ex_waddr, bus.ex_regwrite);
        dep_mem = bool_dep(bus.mem_waddr, bus.mem_regwrite);
        l = 0;
        if (bus.id_is_branch) begin
            if (dep_ex && bus.ex_memread)        l = 2;
            else if (dep_ex)                     l = 1;
            else if (dep_mem && bus.mem_memread) l = 1;
        end else if (dep_ex && bus.ex_memread) begin
            l = 1;
        end
        return l;
    endfunction

    function automatic bit model_stalling();
        return (m_rem > 0) || (calc_len() > 0);
    endfunction

    function automatic bit model_flush();
        return !model_stalling() &&
               (bus.id_is_jump || (bus.id_is_branch && bus.id_branch_taken));
    endfunction

    function automatic longint inc_sat(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem <= 0;
            m_sc  <= 0;
            m_fc  <= 0;
            m_sc4 <= 0;
            m_fc4 <= 0;
        end else begin
            if (model_stalling()) begin
                m_sc  <= inc_sat(m_sc, MAX32);
                m_sc4 <= inc_sat(m_sc4, MAX4);
            end
            if (model_flush()) begin
                m_fc  <= inc_sat(m_fc, MAX32);
                m_fc4 <= inc_sat(m_fc4, MAX4);
            end
            if (m_rem > 0) m_rem <= m_rem - 1;
            else           m_rem <= calc_len();
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("pc_write",    longint'(bus.pc_write),    longint'(!(rst_n && model_stalling())));
        chk("if_id_write", longint'(bus.if_id_write), longint'(!(rst_n && model_stalling())));
        chk("id_ex_flush", longint'(bus.id_ex_flush), longint'(rst_n && model_stalling()));
        chk("if_id_flush", longint'(bus.if_id_flush), longint'(rst_n && model_flush()));
        chk("stall_cnt",   longint'(stall_cnt),       m_sc);
        chk("flush_cnt",   longint'(flush_cnt),       m_fc);
        chk("stall_cnt4",  longint'(stall_cnt4),      m_sc4);
        chk("flush_cnt4",  longint'(flush_cnt4),      m_fc4);
        chk("pc_write4",   longint'(bus4.pc_write),   longint'(bus.pc_write));
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input bit br, input bit jmp, input bit tk,
                          input int exw, input bit exm, input bit exrw,
                          input int mw, input bit mm, input bit mrw);
        bus.id_rs           = 5'(rs);
        bus.id_rt           = 5'(rt);
        bus.id_uses_rs      = urs;
        bus.id_uses_rt      = urt;
        bus.id_is_branch    = br;
        bus.id_is_jump      = jmp;
        bus.id_branch_taken = tk;
        bus.ex_waddr        = 5'(exw);
        bus.ex_memread      = exm;
        bus.ex_regwrite     = exrw;
        bus.mem_waddr       = 5'(mw);
        bus.mem_memread     = mm;
        bus.mem_regwrite    = mrw;
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        // Load-use visible while in reset: outputs must stay free-running
        set_in(8, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        settle();
        chk("rst_pc_write", longint'(bus.pc_write), 1);
        chk("rst_id_ex_flush", longint'(bus.id_ex_flush), 0);
        chk("rst_stall_cnt", longint'(stall_cnt), 0);
        next();
        next();
        rst_n = 1'b1;
        nop();
        settle();
        chk("idle_pc_write", longint'(bus.pc_write), 1);
        next();

        // lw $8 in EX, add reading $8 in ID: detect cycle + STALL1
        set_in(8, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        settle();
        chk("lu_pc_write", longint'(bus.pc_write), 0);
        chk("lu_id_ex_flush", longint'(bus.id_ex_flush), 1);
        next();
        set_in(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 1);
        settle();
        chk("lu_stall1_pc_write", longint'(bus.pc_write), 0);
        next();
        settle();
        chk("lu_done_pc_write", longint'(bus.pc_write), 1);
        chk("lu_stall_cnt", longint'(stall_cnt), 2);
        next();

        // lw $8 in EX, beq on $8 taken: three stalling cycles, then flush
        set_in(8, 0, 1, 0, 1, 0, 1, 8, 1, 1, 0, 0, 0);
        settle();
        chk("br_no_flush_while_stall", longint'(bus.if_id_flush), 0);
        chk("br_pc_write", longint'(bus.pc_write), 0);
        next();
        set_in(8, 0, 1, 0, 1, 0, 1, 0, 0, 0, 8, 1, 1);
        settle();
        chk("br_stall2_pc_write", longint'(bus.pc_write), 0);
        next();
        set_in(8, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("br_stall1_flush", longint'(bus.if_id_flush), 0);
        next();
        settle();
        chk("br_flush", longint'(bus.if_id_flush), 1);
        chk("br_flush_pc_write", longint'(bus.pc_write), 1);
        chk("br_stall_cnt", longint'(stall_cnt), 5);
        next();
        nop();
        settle();
        chk("br_flush_cnt", longint'(flush_cnt), 1);
        next();

        // add $9 in EX, bne reading $9 via rt: length 1
        set_in(0, 9, 0, 1, 1, 0, 0, 9, 0, 1, 0, 0, 0);
        settle();
        chk("alu_br_pc_write", longint'(bus.pc_write), 0);
        next();
        nop();
        next();
        settle();
        chk("alu_br_stall_cnt", longint'(stall_cnt), 7);
        next();
        // lw $9 in MEM, bne reading $9 via rs: length 1
        set_in(9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 9, 1, 1);
        settle();
        chk("mem_br_id_ex_flush", longint'(bus.id_ex_flush), 1);
        next();
        nop();
        next();
        settle();
        chk("mem_br_stall_cnt", longint'(stall_cnt), 9);
        next();

        // $0 destination and unused operand never stall
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        settle();
        chk("r0_pc_write", longint'(bus.pc_write), 1);
        next();
        set_in(8, 0, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        settle();
        chk("unused_rs_pc_write", longint'(bus.pc_write), 1);
        next();
        // j in ID: flush same cycle, PC keeps moving
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("j_flush", longint'(bus.if_id_flush), 1);
        chk("j_pc_write", longint'(bus.pc_write), 1);
        next();
        nop();
        settle();
        chk("j_flush_cnt", longint'(flush_cnt), 2);
        next();

        // Reset asserted during STALL2
        set_in(8, 0, 1, 0, 1, 0, 1, 8, 1, 1, 0, 0, 0);
        next();
        rst_n = 1'b0;
        settle();
        chk("rst_mid_pc_write", longint'(bus.pc_write), 1);
        chk("rst_mid_id_ex_flush", longint'(bus.id_ex_flush), 0);
        next();
        rst_n = 1'b1;
        nop();
        settle();
        chk("post_rst_pc_write", longint'(bus.pc_write), 1);
        chk("post_rst_stall_cnt", longint'(stall_cnt), 0);
        chk("post_rst_flush_cnt", longint'(flush_cnt), 0);
        next();

        // 20 consecutive load-use stall cycles: 4-bit counter pins at 15
        set_in(8, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        repeat (20) next();
        nop();
        settle();
        chk("sat_stall_cnt", longint'(stall_cnt), 20);
        chk("sat_stall_cnt4", longint'(stall_cnt4), 15);
        chk("sat_pc_write", longint'(bus.pc_write), 1);
        next();

        // 20 jump flushes: 4-bit flush counter pins at 15
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) next();
        nop();
        settle();
        chk("sat_flush_cnt", longint'(flush_cnt), 20);
        chk("sat_flush_cnt4", longint'(flush_cnt4), 15);
        chk("sat_hold_stall_cnt4", longint'(stall_cnt4), 15);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
